// File: rtl/debounce_sync.sv
// Synchronizer plus stability-counter debouncer with registered level and edge pulses.
// Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating count of aborted (bounced) changes.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STABLE_CNT  = 1000,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       ce,
    output logic       dout,
    output logic       rise,
    output logic       fall,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output logic       busy,
    output logic [7:0] glitch_cnt
`else
    output logic       busy
`endif
);

    typedef enum logic {
        StStable,
        StPending
    } state_t;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(STABLE_CNT - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       count;
    state_t                 state;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= {SYNC_STAGES{RESET_VAL}};
            dout  <= RESET_VAL;
            count <= '0;
            state <= StStable;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            glitch_cnt <= 8'h00;
`endif
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                StStable: begin
                    count <= '0;
                    busy  <= 1'b0;
                    if (s != dout) begin
                        if (ce && (LastCnt == '0)) begin
                            // Single-cycle qualification commits without a pending cycle
                            dout <= s;
                            rise <= s;
                            fall <= ~s;
                        end else begin
                            state <= StPending;
                            count <= CNT_W'(ce);
                            busy  <= 1'b1;
                        end
                    end
                end
                StPending: begin
                    if (s == dout) begin
                        state <= StStable;
                        count <= '0;
                        busy  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                        if (glitch_cnt != 8'hFF) begin
                            glitch_cnt <= glitch_cnt + 8'h01;
                        end
`endif
                    end else if (ce && (count == LastCnt)) begin
                        dout  <= s;
                        rise  <= s;
                        fall  <= ~s;
                        count <= '0;
                        state <= StStable;
                        busy  <= 1'b0;
                    end else begin
                        count <= count + CNT_W'(ce);
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= StStable;
                    count <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed self-checking bench for debounce_sync with STABLE_CNT=4, SYNC_STAGES=2.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic ce  = 1'b1;
    logic dout, rise, fall, busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] obs, exp;

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES(2),
        .CNT_W      (16),
        .STABLE_CNT (4),
        .RESET_VAL  (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .ce  (ce),
        .dout(dout),
        .rise(rise),
        .fall(fall),
`ifdef DEBOUNCE_GLITCH_CNT_EN
        .busy(busy),
        .glitch_cnt(glitch_cnt)
`else
        .busy(busy)
`endif
    );

    // Advance one edge and settle before inputs change or outputs are sampled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic dval);
        rst = 1'b1;
        din = dval;
        ce  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        ce  = 1'b1;
        tick();
        tick();
        obs = {dout, rise, fall, busy};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_state {dout,rise,fall,busy}=%b expected 0000", obs);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_checks++;
        if (glitch_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_glitch glitch_cnt=%h expected 00", glitch_cnt);
        end
`endif
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            obs = {dout, rise, fall, busy};
            exp = {k >= 6, k == 6, 1'b0, (k >= 3) && (k <= 5)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL reset_release cyc=%0d {dout,rise,fall,busy}=%b expected %b",
                         k, obs, exp);
            end
        end
    endtask

    task automatic test_clean_step();
        do_reset(1'b0);
        din = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {dout, rise, fall, busy};
            exp = {k >= 6, k == 6, 1'b0, (k >= 3) && (k <= 5)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL clean_rise cyc=%0d {dout,rise,fall,busy}=%b expected %b",
                         k, obs, exp);
            end
        end
        din = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {dout, rise, fall, busy};
            exp = {k < 6, 1'b0, k == 6, (k >= 3) && (k <= 5)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL clean_fall cyc=%0d {dout,rise,fall,busy}=%b expected %b",
                         k, obs, exp);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset(1'b0);
        for (int k = 1; k <= 10; k++) begin
            din = (k == 3) ? 1'b0 : 1'b1;
            tick();
            obs = {dout, rise, fall, busy};
            exp = {k >= 9, k == 9, 1'b0, (k == 3) || (k == 4) || ((k >= 6) && (k <= 8))};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL bounce cyc=%0d {dout,rise,fall,busy}=%b expected %b",
                         k, obs, exp);
            end
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_checks++;
        if (glitch_cnt !== 8'h01) begin
            n_fail++;
            $display("FAIL bounce_glitch glitch_cnt=%h expected 01", glitch_cnt);
        end
`endif
    endtask

    task automatic test_prescale();
        do_reset(1'b0);
        din = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            ce = ((k % 3) == 0);
            tick();
            obs = {dout, rise, fall, busy};
            exp = {k >= 12, k == 12, 1'b0, (k >= 3) && (k <= 11)};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL prescale cyc=%0d {dout,rise,fall,busy}=%b expected %b",
                         k, obs, exp);
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        din = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        obs = {dout, rise, fall, busy};
        n_checks++;
        if (obs !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_pending {dout,rise,fall,busy}=%b expected 0001", obs);
        end
        rst = 1'b1;
        tick();
        obs = {dout, rise, fall, busy};
        n_checks++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset {dout,rise,fall,busy}=%b expected 0000", obs);
        end
        din = 1'b0;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {dout, rise, fall, busy};
            n_checks++;
            if (obs !== 4'b0000) begin
                n_fail++;
                $display("FAIL mid_after cyc=%0d {dout,rise,fall,busy}=%b expected 0000",
                         k, obs);
            end
        end
    endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
    task automatic test_glitch_sat();
        do_reset(1'b0);
        // Toggling din aborts once every two edges, starting at edge 4
        for (int i = 0; i < 20; i++) begin
            din = ((i % 2) == 0);
            tick();
        end
        n_checks++;
        if (glitch_cnt !== 8'd9) begin
            n_fail++;
            $display("FAIL glitch_count glitch_cnt=%0d expected 9", glitch_cnt);
        end
        for (int i = 20; i < 640; i++) begin
            din = ((i % 2) == 0);
            tick();
        end
        din = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (glitch_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL glitch_sat glitch_cnt=%h expected ff", glitch_cnt);
        end
        n_checks++;
        if (dout !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_dout dout=%b expected 0", dout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_prescale();
        test_reset_mid();
`ifdef DEBOUNCE_GLITCH_CNT_EN
        test_glitch_sat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Input conditioning stage that feeds the d input of the team's D flip-flop with a clean, clock-domain-safe level.
- Takes an asynchronous, bouncy input (button, external strobe, cross-domain flag) and synchronizes it through a configurable flop chain.
- Filters the synchronized value with a stability counter.
- Outputs a debounced level plus single-cycle rise/fall pulses for downstream registers.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal 2..4).
- CNT_W, 16, width of the stability counter.
- STABLE_CNT, 1000, consecutive qualifying cycles the synced input must differ from dout before dout changes (legal 1..2^CNT_W-1).
- RESET_VAL, 1'b0, value loaded into synchronizer chain and dout on reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high; dominates all other inputs.
- din  input  1  raw asynchronous input.
- ce  input  1  count enable/prescale tick; counter advances only when high.
- dout  output  1  debounced, registered level.
- rise  output  1  one-cycle pulse coincident with dout 0->1.
- fall  output  1  one-cycle pulse coincident with dout 1->0.
- busy  output  1  high while a candidate change is pending (state PENDING).

Behaviour:
- Reset, sampled at posedge with rst=1:
  - synchronizer chain = RESET_VAL
  - dout = RESET_VAL
  - counter = 0
  - state = STABLE
  - rise = fall = busy = 0
- Reset mid-PENDING discards the pending change; no pulse is generated.
- Synchronizer: din shifts through SYNC_STAGES flops every cycle, regardless of ce; s = last stage.
- State machine (2 states):
  - STABLE:
    - s == dout: stay; counter held at 0.
    - s != dout: go to PENDING; counter = 1 if ce else 0.
  - PENDING:
    - s == dout (bounce): return to STABLE; counter = 0; dout unchanged; no pulse.
    - s != dout and ce and counter == STABLE_CNT-1: dout <= s; counter = 0; state = STABLE; rise or fall = 1 for this one cycle.
    - s != dout otherwise: counter += ce.
  - STABLE_CNT=1: from STABLE, s != dout with ce=1 updates dout directly in the same edge; no PENDING cycle, busy never asserts.
- busy = (state == PENDING), registered.
- Pulses:
  - rise/fall are registered and asserted in the same cycle dout changes; never both high.
  - Cleared on the next edge.
- Latency, ce held at 1: din step to dout change = SYNC_STAGES + STABLE_CNT cycles.
- Counter never wraps; it only reaches STABLE_CNT-1 and then clears.
- ce low freezes the counter but not the bounce check: a mismatch loss while ce=0 still aborts to STABLE.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds output glitch_cnt [7:0].
  - Increments by 1 on every PENDING->STABLE abort (bounce); saturates at 8'hFF.
  - Cleared to 0 by rst.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan (STABLE_CNT=4, SYNC_STAGES=2, RESET_VAL=0, ce=1 unless stated):
- Reset: rst=1 for 2 cycles with din=1 -> dout=0, rise=fall=busy=0; after release, dout rises at cycle 6 with rise=1 for exactly 1 cycle.
- Clean step: din 0->1 held -> busy high cycles 3..5, dout=1 at cycle 6, rise pulse at cycle 6 only; later din 1->0 -> fall pulse 6 cycles after.
- Bounce: din=1 for 2 cycles, 0 for 1, 1 held -> first pending aborts, no pulse, dout=1 only 6 cycles after the final rise; glitch_cnt=1 if enabled.
- Prescale: ce high every 3rd cycle, din step held -> dout changes exactly on the 4th ce-high cycle counted from PENDING entry; no change between ticks.
- Reset mid-operation: rst asserted during PENDING with counter=2 -> next cycle busy=0, dout=RESET_VAL, no rise/fall.
- Saturation (DEBOUNCE_GLITCH_CNT_EN): 300 aborted bounces -> glitch_cnt=8'hFF, dout unchanged.
